pipe_hazard_ctrl: RTL and testbench

//  Parametrised pipeline hazard/control unit for the 5-stage ARM core; successor to the fixed hazard detector.

---
 rtl/arm_pipe_pkg.sv | 13 +
 rtl/pipe_shadow_slot.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 87 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// arm_pipe_pkg: forwarding select codes and EX shadow-slot control bits shared by the hazard unit
package arm_pipe_pkg;
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  typedef struct packed {
    logic v;
    logic wb_en;
    logic mem_r_en;
    logic two_src;
  } slot_ctl_t;
  localparam int CTL_W = $bits(slot_ctl_t);
endpackage

// File: rtl/pipe_shadow_slot.sv
// pipe_shadow_slot: one pipeline shadow register, cleared by reset and frozen while i_hold is high
module pipe_shadow_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_hold,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk)
    if (!rst) r_q <= '0;
    else if (!i_hold) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ARM 5-stage hazard unit with EX/MEM/WB shadow slots, freeze/bubble/flush
// control, operand forwarding selects and a saturating hazard-stall counter
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             freeze,
  output logic             bubble_ex,
  output logic             flush,
  output logic             pipe_hold,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int EX_W = CTL_W + 3 * REG_W;
  localparam int DW_W = 2 + REG_W;
  slot_ctl_t w_ex_ctl, w_ex_ctl_d;
  logic [EX_W-1:0] w_ex_q;
  logic [DW_W-1:0] w_mem_q, w_wb_q;
  logic [REG_W-1:0] w_ex_dest, w_ex_src1, w_ex_src2, w_mem_dest, w_wb_dest;
  logic w_mem_v, w_mem_wb_en, w_wb_v, w_wb_wb_en;
  logic w_m_ex1, w_m_ex2, w_m_mem1, w_m_mem2, w_flush, w_stall;
  logic [CNT_W-1:0] r_stall_cnt;

  function automatic logic match(input logic v, input logic wb_en,
                                 input logic [REG_W-1:0] dest, input logic [REG_W-1:0] s);
    return v && wb_en && dest == s && s != REG_W'(PC_REG);
  endfunction

  assign w_ex_ctl_d = '{v: id_valid && !hazard && !w_flush, wb_en: id_wb_en,
                        mem_r_en: id_mem_r_en, two_src: id_two_src};

  // MEM/WB only need the destination side; sources are kept in EX for forwarding
  pipe_shadow_slot #(.W(EX_W)) u_ex (.clk(clk), .rst(rst), .i_hold(mem_busy),
    .i_d({w_ex_ctl_d, id_dest, id_src1, id_src2}), .o_q(w_ex_q));
  pipe_shadow_slot #(.W(DW_W)) u_mem (.clk(clk), .rst(rst), .i_hold(mem_busy),
    .i_d({w_ex_ctl.v, w_ex_ctl.wb_en, w_ex_dest}), .o_q(w_mem_q));
  pipe_shadow_slot #(.W(DW_W)) u_wb (.clk(clk), .rst(rst), .i_hold(mem_busy),
    .i_d(w_mem_q), .o_q(w_wb_q));

  assign {w_ex_ctl, w_ex_dest, w_ex_src1, w_ex_src2} = w_ex_q;
  assign {w_mem_v, w_mem_wb_en, w_mem_dest} = w_mem_q;
  assign {w_wb_v, w_wb_wb_en, w_wb_dest} = w_wb_q;

  assign w_m_ex1  = match(w_ex_ctl.v, w_ex_ctl.wb_en, w_ex_dest, id_src1);
  assign w_m_ex2  = id_two_src && match(w_ex_ctl.v, w_ex_ctl.wb_en, w_ex_dest, id_src2);
  assign w_m_mem1 = match(w_mem_v, w_mem_wb_en, w_mem_dest, id_src1);
  assign w_m_mem2 = id_two_src && match(w_mem_v, w_mem_wb_en, w_mem_dest, id_src2);

  assign hazard = id_valid && (FWD_EN ? w_ex_ctl.mem_r_en && (w_m_ex1 || w_m_ex2)
                                      : w_m_ex1 || w_m_ex2 || w_m_mem1 || w_m_mem2);
  assign w_flush   = ex_branch_taken && !mem_busy;
  assign w_stall   = hazard && !ex_branch_taken && !mem_busy;
  assign flush     = w_flush;
  assign bubble_ex = w_stall;
  assign freeze    = mem_busy || (hazard && !ex_branch_taken);
  assign pipe_hold = mem_busy;

  assign fwd_sel_a = !FWD_EN ? FWD_RF
                   : match(w_mem_v, w_mem_wb_en, w_mem_dest, w_ex_src1) ? FWD_MEM
                   : match(w_wb_v, w_wb_wb_en, w_wb_dest, w_ex_src1) ? FWD_WB : FWD_RF;
  assign fwd_sel_b = !FWD_EN || !w_ex_ctl.two_src ? FWD_RF
                   : match(w_mem_v, w_mem_wb_en, w_mem_dest, w_ex_src2) ? FWD_MEM
                   : match(w_wb_v, w_wb_wb_en, w_wb_dest, w_ex_src2) ? FWD_WB : FWD_RF;

  always_ff @(posedge clk)
    if (!rst || perf_clr) r_stall_cnt <= '0;
    else if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: stalling (index 0) and forwarding (index 1) hazard units driven in parallel
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid = 0, id_two_src = 0, id_wb_en = 0, id_mem_r_en = 0;
  logic [3:0] id_src1 = 0, id_src2 = 0, id_dest = 0;
  logic ex_branch_taken = 0, mem_busy = 0, perf_clr = 0;
  logic [1:0] frz_o, bub_o, fl_o, hold_o, haz_o;
  logic [1:0] fa_o [2];
  logic [1:0] fb_o [2];
  logic [3:0] cnt_o [2];
  int n_vec = 0, n_bad = 0, nh;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(4), .PC_REG(15), .FWD_EN(1'b0), .CNT_W(4)) u_stall (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .freeze(frz_o[0]), .bubble_ex(bub_o[0]), .flush(fl_o[0]), .pipe_hold(hold_o[0]),
    .fwd_sel_a(fa_o[0]), .fwd_sel_b(fb_o[0]), .hazard(haz_o[0]), .stall_cnt(cnt_o[0]));
  pipe_hazard_ctrl #(.REG_W(4), .PC_REG(15), .FWD_EN(1'b1), .CNT_W(4)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .freeze(frz_o[1]), .bubble_ex(bub_o[1]), .flush(fl_o[1]), .pipe_hold(hold_o[1]),
    .fwd_sel_a(fa_o[1]), .fwd_sel_b(fb_o[1]), .hazard(haz_o[1]), .stall_cnt(cnt_o[1]));

  // reference model: the last three instructions that left ID, per mode
  typedef struct packed {logic v, wb, ld, two; logic [3:0] d, s1, s2;} ins_t;
  ins_t st[2][3];
  int cnt[2];

  typedef struct {
    logic v, two, wb, ld, br;
    logic [3:0] s1, s2, d;
    logic haz, frz, bub, fl;
    logic [1:0] fa, fb;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl[10];

  function automatic bit wr(ins_t i, logic [3:0] r);
    return i.v && i.wb && i.d == r && r != 4'd15;
  endfunction

  function automatic bit haz_m(int m);
    bit e, p;
    e = wr(st[m][0], id_src1) || (id_two_src && wr(st[m][0], id_src2));
    p = wr(st[m][1], id_src1) || (id_two_src && wr(st[m][1], id_src2));
    if (!id_valid) return 0;
    return (m == 1) ? (st[m][0].ld && e) : (e || p);
  endfunction

  function automatic logic [1:0] fwd_m(int m, logic [3:0] r, logic use_r);
    if (m == 0 || !use_r) return 2'd0;
    if (wr(st[m][1], r)) return 2'd1;
    return wr(st[m][2], r) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [3:0] rr();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model();
    for (int m = 0; m < 2; m++) begin
      logic h;
      h = haz_m(m);
      chk($sformatf("m%0d hazard", m), haz_o[m], h);
      chk($sformatf("m%0d freeze", m), frz_o[m], mem_busy || (h && !ex_branch_taken));
      chk($sformatf("m%0d bubble", m), bub_o[m], h && !ex_branch_taken && !mem_busy);
      chk($sformatf("m%0d flush", m), fl_o[m], ex_branch_taken && !mem_busy);
      chk($sformatf("m%0d pipe_hold", m), hold_o[m], mem_busy);
      chk($sformatf("m%0d fwd_a", m), fa_o[m], fwd_m(m, st[m][0].s1, 1'b1));
      chk($sformatf("m%0d fwd_b", m), fb_o[m], fwd_m(m, st[m][0].s2, st[m][0].two));
      chk($sformatf("m%0d stall_cnt", m), cnt_o[m], cnt[m]);
    end
  endtask

  task automatic model_adv();
    for (int m = 0; m < 2; m++) begin
      logic h;
      h = haz_m(m);
      if (!rst) begin
        for (int k = 0; k < 3; k++) st[m][k] = '0;
        cnt[m] = 0;
      end else begin
        if (perf_clr) cnt[m] = 0;
        else if (h && !ex_branch_taken && !mem_busy && cnt[m] < 15) cnt[m]++;
        if (!mem_busy) begin
          st[m][2] = st[m][1];
          st[m][1] = st[m][0];
          st[m][0] = '{v: id_valid && !h && !ex_branch_taken, wb: id_wb_en, ld: id_mem_r_en,
                       two: id_two_src, d: id_dest, s1: id_src1, s2: id_src2};
        end
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic cyc();
    at_neg();
    check_model();
    adv();
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2, input logic two,
                        input logic [3:0] d, input logic wb, input logic ld);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_dest = d; id_wb_en = wb; id_mem_r_en = ld;
  endtask

  task automatic reset_dut();
    rst = 0; set_id(0, 0, 0, 0, 0, 0, 0);
    ex_branch_taken = 0; mem_busy = 0; perf_clr = 0;
    adv(); adv();
    rst = 1;
  endtask

  initial begin
    tbl[0] = '{1,0,1,1,0, 2,0,1, 0,0,0,0, 0,0,0};
    tbl[1] = '{1,1,1,0,0, 1,5,4, 1,1,1,0, 0,0,0};
    tbl[2] = '{1,1,1,0,0, 1,5,4, 0,0,0,0, 1,0,1};
    tbl[3] = '{0,0,0,0,0, 0,0,0, 0,0,0,0, 2,0,1};
    tbl[4] = '{1,1,1,0,0, 4,4,4, 0,0,0,0, 0,0,1};
    tbl[5] = '{1,0,1,0,0, 9,0,4, 0,0,0,0, 2,2,1};
    tbl[6] = '{1,0,1,0,0, 4,0,4, 0,0,0,0, 0,0,1};
    tbl[7] = '{1,0,1,1,0, 4,0,7, 0,0,0,0, 1,0,1};
    tbl[8] = '{1,0,1,0,1, 7,0,8, 1,0,0,1, 1,0,1};
    tbl[9] = '{1,0,1,0,0, 8,0,9, 0,0,0,0, 1,0,1};

    reset_dut();
    at_neg();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset m%0d freeze", m), frz_o[m], 0);
      chk($sformatf("reset m%0d flush", m), fl_o[m], 0);
      chk($sformatf("reset m%0d fwd_a", m), fa_o[m], 0);
      chk($sformatf("reset m%0d stall_cnt", m), cnt_o[m], 0);
    end
    check_model();
    adv();

    // load-use, forwarding priority, branch overriding a hazard (forwarding unit)
    for (int i = 0; i < 10; i++) begin
      set_id(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].d, tbl[i].wb, tbl[i].ld);
      ex_branch_taken = tbl[i].br;
      at_neg();
      chk($sformatf("tbl%0d hazard", i), haz_o[1], tbl[i].haz);
      chk($sformatf("tbl%0d freeze", i), frz_o[1], tbl[i].frz);
      chk($sformatf("tbl%0d bubble", i), bub_o[1], tbl[i].bub);
      chk($sformatf("tbl%0d flush", i), fl_o[1], tbl[i].fl);
      chk($sformatf("tbl%0d fwd_a", i), fa_o[1], tbl[i].fa);
      chk($sformatf("tbl%0d fwd_b", i), fb_o[1], tbl[i].fb);
      chk($sformatf("tbl%0d stall_cnt", i), cnt_o[1], tbl[i].cnt);
      check_model();
      adv();
    end
    ex_branch_taken = 0;

    // stalling unit: src2 only counts when read; PC never hazards
    reset_dut();
    set_id(1, 0, 0, 0, 3, 1, 0); cyc();
    set_id(0, 0, 0, 0, 0, 0, 0); cyc();
    mem_busy = 1; set_id(1, 0, 3, 1, 9, 1, 0);
    at_neg();
    chk("stall src2 hazard", haz_o[0], 1);
    chk("stall busy freeze", frz_o[0], 1);
    chk("stall busy bubble", bub_o[0], 0);
    id_two_src = 0; #1;
    chk("stall src2 unread", haz_o[0], 0);
    check_model();
    adv();
    mem_busy = 0; set_id(1, 0, 0, 0, 15, 1, 0); cyc();
    set_id(1, 15, 15, 1, 9, 1, 0);
    at_neg();
    chk("stall pc src", haz_o[0], 0);
    check_model();
    adv();

    // memory stall holds a taken branch until it drops
    ex_branch_taken = 1; mem_busy = 1;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk($sformatf("busy%0d flush", k), fl_o[1], 0);
      chk($sformatf("busy%0d freeze", k), frz_o[1], 1);
      check_model();
      adv();
    end
    mem_busy = 0;
    at_neg();
    chk("busy drop flush", fl_o[1], 1);
    check_model();
    adv();
    ex_branch_taken = 0;

    // counter saturation, clear priority, reset mid-stall
    reset_dut();
    set_id(1, 1, 0, 0, 1, 1, 1);
    nh = 0;
    for (int k = 0; k < 200 && nh < 18; k++) begin
      at_neg();
      if (haz_o[1]) nh++;
      check_model();
      adv();
    end
    chk("sat hazard cycles", nh, 18);
    at_neg();
    chk("sat cnt fwd", cnt_o[1], 15);
    chk("sat cnt stall", cnt_o[0], 15);
    for (int k = 0; k < 8 && !haz_o[1]; k++) begin adv(); at_neg(); end
    chk("clr hazard seen", haz_o[1], 1);
    perf_clr = 1;
    check_model();
    adv();
    perf_clr = 0;
    at_neg();
    chk("clr wins", cnt_o[1], 0);
    check_model();
    adv();
    repeat (3) cyc();
    at_neg();
    for (int k = 0; k < 8 && !haz_o[1]; k++) begin adv(); at_neg(); end
    rst = 0;
    adv();
    rst = 1;
    at_neg();
    chk("rst cnt fwd", cnt_o[1], 0);
    chk("rst cnt stall", cnt_o[0], 0);
    chk("rst freeze", frz_o[1], 0);
    chk("rst hazard", haz_o[0], 0);
    check_model();
    adv();

    for (int k = 0; k < 400; k++) begin
      id_valid = $urandom_range(0, 3) != 0;
      id_src1 = rr(); id_src2 = rr(); id_dest = rr();
      id_two_src = $urandom_range(0, 1) != 0;
      id_wb_en = $urandom_range(0, 3) != 0;
      id_mem_r_en = $urandom_range(0, 2) == 0;
      ex_branch_taken = $urandom_range(0, 7) == 0;
      mem_busy = $urandom_range(0, 4) == 0;
      perf_clr = $urandom_range(0, 29) == 0;
      rst = $urandom_range(0, 99) != 0;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
